ibex_multdiv_issue: RTL and testbench

- Request/response sequencer that sits directly upstream of the slow multiplier/divider and feeds it.
- Accepts one MUL/DIV request over a valid/ready handshake, registers the operands, and drives the unit's enable, select, operator and operand inputs until the unit signals valid.
- Captures the 32-bit result and presents it to writeback over a valid/ready handshake.
- Supports a flush that drains an in-flight operation and discards its result.

---
 rtl/ibex_multdiv_issue.sv | 181 ++++++++++++++++++
 tb/tb_ibex_multdiv_issue.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_multdiv_issue.sv
// Issue sequencer in front of the multi-cycle multiplier/divider: accepts one request,
// holds operands steady while the unit works, captures its result and hands it to writeback.
module ibex_multdiv_issue #(
    parameter bit          DataIndTiming = 1'b0,
    parameter int unsigned LatW          = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [1:0]      req_signed_i,
    input  logic [31:0]     req_a_i,
    input  logic [31:0]     req_b_i,
    input  logic            flush_i,
    output logic            md_mult_en_o,
    output logic            md_div_en_o,
    output logic            md_mult_sel_o,
    output logic            md_div_sel_o,
    output logic [1:0]      md_operator_o,
    output logic [1:0]      md_signed_mode_o,
    output logic [31:0]     md_op_a_o,
    output logic [31:0]     md_op_b_o,
    output logic            md_data_ind_timing_o,
    output logic            md_ready_id_o,
    input  logic [31:0]     md_result_i,
    input  logic            md_valid_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [31:0]     rsp_data_o,
    output logic [LatW-1:0] rsp_lat_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [LatW-1:0] LatMax = {LatW{1'b1}};
    localparam logic [LatW-1:0] LatOne = LatW'(1);

    state_e          r_state;
    state_e          w_state_next;
    logic            w_accept;
    logic            w_start;
    logic            w_capture;
    logic            w_keep_en;
    logic [1:0]      r_operator;
    logic [1:0]      r_signed;
    logic [31:0]     r_op_a;
    logic [31:0]     r_op_b;
    logic            r_mult_en;
    logic            r_div_en;
    logic [LatW-1:0] r_lat;
    logic [LatW-1:0] r_rsp_lat;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_valid;

    assign req_ready_o = ~flush_i & ((r_state == S_IDLE) | ((r_state == S_DONE) & rsp_ready_i));
    assign w_accept    = req_valid_i & req_ready_o;

    // Next-state decode; a flush that coincides with the unit's valid needs no drain
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_BUSY;
                    w_start      = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    w_state_next = md_valid_i ? S_IDLE : S_DRAIN;
                end else if (md_valid_i) begin
                    w_state_next = S_DONE;
                    w_capture    = 1'b1;
                end else begin
                    w_state_next = S_BUSY;
                end
            end
            S_DRAIN: begin
                if (md_valid_i) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DONE: begin
                if (flush_i) begin
                    w_state_next = S_IDLE;
                end else if (rsp_ready_i) begin
                    w_state_next = w_accept ? S_BUSY : S_IDLE;
                    w_start      = w_accept;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_keep_en = (w_state_next == S_BUSY) | (w_state_next == S_DRAIN);
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand and enable registers: loaded on accept, held while the unit owns them
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_operator <= 2'd0;
            r_signed   <= 2'd0;
            r_op_a     <= 32'd0;
            r_op_b     <= 32'd0;
            r_mult_en  <= 1'b0;
            r_div_en   <= 1'b0;
        end else if (w_start) begin
            r_operator <= req_op_i;
            r_signed   <= req_signed_i;
            r_op_a     <= req_a_i;
            r_op_b     <= req_b_i;
            r_mult_en  <= ~req_op_i[1];
            r_div_en   <= req_op_i[1];
        end else begin
            r_mult_en  <= r_mult_en & w_keep_en;
            r_div_en   <= r_div_en & w_keep_en;
        end
    end

    // Busy-cycle counter and captured response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lat       <= {LatW{1'b0}};
            r_rsp_lat   <= {LatW{1'b0}};
            r_rsp_data  <= 32'd0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_start) begin
                r_lat <= {LatW{1'b0}};
            end else if ((r_state == S_BUSY) && (r_lat != LatMax)) begin
                r_lat <= r_lat + LatOne;
            end else begin
                r_lat <= r_lat;
            end
            if (w_capture) begin
                r_rsp_data <= md_result_i;
                r_rsp_lat  <= r_lat;
            end else begin
                r_rsp_data <= r_rsp_data;
                r_rsp_lat  <= r_rsp_lat;
            end
            r_rsp_valid <= (w_state_next == S_DONE);
        end
    end

    assign md_mult_en_o         = r_mult_en;
    assign md_mult_sel_o        = r_mult_en;
    assign md_div_en_o          = r_div_en;
    assign md_div_sel_o         = r_div_en;
    assign md_operator_o        = r_operator;
    assign md_signed_mode_o     = r_signed;
    assign md_op_a_o            = r_op_a;
    assign md_op_b_o            = r_op_b;
    assign md_data_ind_timing_o = DataIndTiming;
    assign md_ready_id_o        = 1'b1;
    assign rsp_valid_o          = r_rsp_valid;
    assign rsp_data_o           = r_rsp_data;
    assign rsp_lat_o            = r_rsp_lat;
endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Directed bench for ibex_multdiv_issue; a small behavioural multiplier/divider stands in for the unit.
module tb_ibex_multdiv_issue;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [1:0]  req_op;
    logic [1:0]  req_signed;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush [2];
    logic        mult_en [2];
    logic        div_en [2];
    logic        mult_sel [2];
    logic        div_sel [2];
    logic [1:0]  md_operator [2];
    logic [1:0]  md_signed [2];
    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic        dit [2];
    logic        ready_id [2];
    logic [31:0] md_result [2];
    logic        md_valid [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data [2];
    logic [5:0]  rsp_lat0;
    logic [4:0]  rsp_lat1;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ibex_multdiv_issue #(.DataIndTiming(1'b0), .LatW(6)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_op_i(req_op), .req_signed_i(req_signed), .req_a_i(req_a), .req_b_i(req_b),
        .flush_i(flush[0]), .md_mult_en_o(mult_en[0]), .md_div_en_o(div_en[0]),
        .md_mult_sel_o(mult_sel[0]), .md_div_sel_o(div_sel[0]), .md_operator_o(md_operator[0]),
        .md_signed_mode_o(md_signed[0]), .md_op_a_o(op_a[0]), .md_op_b_o(op_b[0]),
        .md_data_ind_timing_o(dit[0]), .md_ready_id_o(ready_id[0]), .md_result_i(md_result[0]),
        .md_valid_i(md_valid[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
        .rsp_data_o(rsp_data[0]), .rsp_lat_o(rsp_lat0)
    );

    ibex_multdiv_issue #(.DataIndTiming(1'b1), .LatW(5)) u_dut_dit (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_op_i(req_op), .req_signed_i(req_signed), .req_a_i(req_a), .req_b_i(req_b),
        .flush_i(flush[1]), .md_mult_en_o(mult_en[1]), .md_div_en_o(div_en[1]),
        .md_mult_sel_o(mult_sel[1]), .md_div_sel_o(div_sel[1]), .md_operator_o(md_operator[1]),
        .md_signed_mode_o(md_signed[1]), .md_op_a_o(op_a[1]), .md_op_b_o(op_b[1]),
        .md_data_ind_timing_o(dit[1]), .md_ready_id_o(ready_id[1]), .md_result_i(md_result[1]),
        .md_valid_i(md_valid[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
        .rsp_data_o(rsp_data[1]), .rsp_lat_o(rsp_lat1)
    );

    function automatic logic [31:0] md_compute(input logic [1:0] op, input logic [1:0] sg,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] sa, sb, q, r;
        logic signed [65:0] p;
        sa = {sg[0] & a[31], a};
        sb = {sg[1] & b[31], b};
        p  = sa * sb;
        if (b == 32'd0) begin
            q = '1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        case (op)
            2'd0:    return p[31:0];
            2'd1:    return p[63:32];
            2'd2:    return q[31:0];
            default: return r[31:0];
        endcase
    endfunction

    function automatic int unit_lat(input logic is_div, input logic ind, input logic [31:0] b);
        if (!is_div) return 3;
        if (ind) return 34;
        return (b == 32'd0) ? 2 : 10;
    endfunction

    function automatic logic [5:0] get_lat(input int d);
        return (d == 0) ? rsp_lat0 : {1'b0, rsp_lat1};
    endfunction

    function automatic logic [5:0] lat_exp(input int d, input int blat);
        int mx;
        mx = (d == 0) ? 63 : 31;
        return (blat > mx) ? 6'(mx) : 6'(blat);
    endfunction

    // Behavioural unit: starts on enable, runs, raises valid for one cycle, then a finish cycle
    typedef enum logic [1:0] {U_IDLE, U_RUN, U_FIN} ust_e;
    ust_e ust [2];
    int   ucnt [2];
    logic [31:0] ures [2];
    always @(posedge clk or posedge rst) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                ust[u] <= U_IDLE; ucnt[u] <= 0; md_valid[u] <= 1'b0;
                md_result[u] <= 32'hDEADBEEF; ures[u] <= 32'd0;
            end else begin
                case (ust[u])
                    U_IDLE: if (mult_en[u] || div_en[u]) begin
                        ust[u]  <= U_RUN;
                        ucnt[u] <= unit_lat(div_en[u], dit[u], op_b[u]);
                        ures[u] <= md_compute(md_operator[u], md_signed[u], op_a[u], op_b[u]);
                    end
                    U_RUN: if (ucnt[u] <= 1) begin
                        ust[u] <= U_FIN; md_valid[u] <= 1'b1; md_result[u] <= ures[u];
                    end else begin
                        ucnt[u] <= ucnt[u] - 1;
                    end
                    default: begin
                        ust[u] <= U_IDLE; md_valid[u] <= 1'b0; md_result[u] <= 32'hDEADBEEF;
                    end
                endcase
            end
        end
    end

    task automatic send(input int d, input logic [1:0] op, input logic [1:0] sg,
                        input logic [31:0] a, input logic [31:0] b, output bit acc);
        @(negedge clk);
        req_op = op; req_signed = sg; req_a = a; req_b = b; req_valid[d] = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            #1;
            acc = req_ready[d];
            if (!acc) @(negedge clk);
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, input logic [31:0] ea, input logic [31:0] eb, output bit got,
                            output int blat, output bit held, output logic [3:0] en_first,
                            output logic en_after);
        int n;
        n = 0; got = 1'b0; held = 1'b1; en_first = 4'd0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) en_first = {mult_en[d], mult_sel[d], div_en[d], div_sel[d]};
            if (op_a[d] !== ea || op_b[d] !== eb) held = 1'b0;
            if (md_valid[d] === 1'b1) break;
        end
        blat = n - 1;
        @(negedge clk);
        got = (rsp_valid[d] === 1'b1);
        en_after = mult_en[d] | div_en[d] | mult_sel[d] | div_sel[d];
    endtask

    task automatic do_op(input int d, input logic [1:0] op, input logic [1:0] sg,
                         input logic [31:0] a, input logic [31:0] b, output bit ok, output int blat,
                         output bit held, output logic [3:0] en_first, output logic en_after);
        bit acc, got;
        send(d, op, sg, a, b, acc);
        wait_rsp(d, a, b, got, blat, held, en_first, en_after);
        ok = acc & got;
    endtask

    task automatic take(input int d);
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready[0]); end
        n_checks++;
        if ({mult_en[0], div_en[0], mult_sel[0], div_sel[0], rsp_valid[0]} !== 5'b0) begin
            n_fail++; $display("FAIL reset_en_valid: got %b want 00000", {mult_en[0], div_en[0], mult_sel[0], div_sel[0], rsp_valid[0]});
        end
        n_checks++;
        if ({md_operator[0], md_signed[0], op_a[0], op_b[0]} !== 68'd0) begin
            n_fail++; $display("FAIL reset_operands: got %h want 0", {md_operator[0], md_signed[0], op_a[0], op_b[0]});
        end
        n_checks++;
        if (rsp_data[0] !== 32'd0 || rsp_lat0 !== 6'd0) begin
            n_fail++; $display("FAIL reset_rsp: got %h/%0d want 0/0", rsp_data[0], rsp_lat0);
        end
        n_checks++;
        if (ready_id[0] !== 1'b1 || dit[0] !== 1'b0 || dit[1] !== 1'b1) begin
            n_fail++; $display("FAIL reset_const: got ready_id=%b dit0=%b dit1=%b want 1 0 1", ready_id[0], dit[0], dit[1]);
        end
    endtask

    task automatic test_mull_hold();
        bit ok, held; int blat; logic [3:0] enf; logic ena; logic [31:0] dh; logic [5:0] lh;
        do_op(0, 2'd0, 2'b11, 32'd7, 32'hFFFFFFFD, ok, blat, held, enf, ena);
        n_checks++;
        if (!ok || rsp_data[0] !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mull_data: got ok=%b %h want 1 ffffffeb", ok, rsp_data[0]); end
        n_checks++;
        if (enf !== 4'b1100 || ena !== 1'b0) begin n_fail++; $display("FAIL mull_en: got %b/%b want 1100/0", enf, ena); end
        n_checks++;
        if (!held) begin n_fail++; $display("FAIL mull_operands_held: got changed want stable"); end
        n_checks++;
        if (rsp_lat0 !== lat_exp(0, blat)) begin n_fail++; $display("FAIL mull_lat: got %0d want %0d", rsp_lat0, lat_exp(0, blat)); end
        dh = rsp_data[0]; lh = rsp_lat0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== dh || rsp_lat0 !== lh || req_ready[0] !== 1'b0) begin
                n_fail++; $display("FAIL mull_hold%0d: got v=%b %h/%0d rdy=%b want 1 %h/%0d 0", i, rsp_valid[0], rsp_data[0], rsp_lat0, req_ready[0], dh, lh);
            end
        end
        take(0);
        @(negedge clk);
        n_checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL mull_release: got v=%b rdy=%b want 0 1", rsp_valid[0], req_ready[0]);
        end
    endtask

    task automatic test_mulh_div();
        bit ok, held; int blat; logic [3:0] enf; logic ena;
        do_op(0, 2'd1, 2'b11, 32'h80000000, 32'h80000000, ok, blat, held, enf, ena);
        n_checks++;
        if (!ok || rsp_data[0] !== 32'h40000000) begin n_fail++; $display("FAIL mulh_ss: got ok=%b %h want 1 40000000", ok, rsp_data[0]); end
        take(0);
        do_op(0, 2'd1, 2'b00, 32'h80000000, 32'h80000000, ok, blat, held, enf, ena);
        n_checks++;
        if (!ok || rsp_data[0] !== 32'h40000000) begin n_fail++; $display("FAIL mulh_uu: got ok=%b %h want 1 40000000", ok, rsp_data[0]); end
        take(0);
        do_op(0, 2'd2, 2'b11, 32'h80000000, 32'hFFFFFFFF, ok, blat, held, enf, ena);
        n_checks++;
        if (!ok || rsp_data[0] !== 32'h80000000 || enf !== 4'b0011 || !held) begin
            n_fail++; $display("FAIL div_ovf: got ok=%b %h en=%b held=%b want 1 80000000 0011 1", ok, rsp_data[0], enf, held);
        end
        take(0);
    endtask

    task automatic test_div_zero();
        bit ok, held; int blat; logic [3:0] enf; logic ena;
        logic [5:0] lat_div [2];
        logic [5:0] lat_rem [2];
        for (int d = 0; d < 2; d++) begin
            do_op(d, 2'd2, 2'b11, 32'd5, 32'd0, ok, blat, held, enf, ena);
            n_checks++;
            if (!ok || rsp_data[d] !== 32'hFFFFFFFF || get_lat(d) !== lat_exp(d, blat)) begin
                n_fail++; $display("FAIL div0_dut%0d: got ok=%b %h lat=%0d want 1 ffffffff %0d", d, ok, rsp_data[d], get_lat(d), lat_exp(d, blat));
            end
            lat_div[d] = get_lat(d);
            take(d);
            do_op(d, 2'd3, 2'b11, 32'd5, 32'd0, ok, blat, held, enf, ena);
            n_checks++;
            if (!ok || rsp_data[d] !== 32'd5 || get_lat(d) !== lat_exp(d, blat)) begin
                n_fail++; $display("FAIL rem0_dut%0d: got ok=%b %h lat=%0d want 1 00000005 %0d", d, ok, rsp_data[d], get_lat(d), lat_exp(d, blat));
            end
            lat_rem[d] = get_lat(d);
            take(d);
        end
        n_checks++;
        if (!(lat_div[1] > lat_div[0]) || !(lat_rem[1] > lat_rem[0])) begin
            n_fail++; $display("FAIL dit_lat_larger: got div %0d vs %0d rem %0d vs %0d want dit larger", lat_div[1], lat_div[0], lat_rem[1], lat_rem[0]);
        end
        n_checks++;
        if (lat_div[1] !== 6'd31) begin n_fail++; $display("FAIL dit_lat_saturate: got %0d want 31", lat_div[1]); end
    endtask

    task automatic test_flush();
        bit acc, ok, held, seen, en_ok, saw_rsp, rdy_bad; int blat; logic [3:0] enf; logic ena;
        send(0, 2'd2, 2'b11, 32'd1000, 32'd3, acc);
        repeat (3) @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk);
        #1 flush[0] = 1'b0;
        seen = 1'b0; en_ok = 1'b1; saw_rsp = 1'b0; rdy_bad = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (div_en[0] !== 1'b1 || div_sel[0] !== 1'b1) en_ok = 1'b0;
            if (rsp_valid[0] !== 1'b0) saw_rsp = 1'b1;
            if (req_ready[0] !== 1'b0) rdy_bad = 1'b1;
            if (md_valid[0] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!acc || !seen || !en_ok || rdy_bad) begin
            n_fail++; $display("FAIL flush_drain: got acc=%b seen=%b en_held=%b rdy_in_drain=%b want 1 1 1 0", acc, seen, en_ok, rdy_bad);
        end
        @(negedge clk);
        n_checks++;
        if (div_en[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL flush_idle: got div_en=%b rdy=%b want 0 1", div_en[0], req_ready[0]);
        end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) saw_rsp = 1'b1;
        end
        n_checks++;
        if (saw_rsp) begin n_fail++; $display("FAIL flush_no_rsp: got rsp_valid want none"); end
        do_op(0, 2'd0, 2'b00, 32'd3, 32'd4, ok, blat, held, enf, ena);
        n_checks++;
        if (!ok || rsp_data[0] !== 32'd12) begin n_fail++; $display("FAIL flush_next_mull: got ok=%b %0d want 1 12", ok, rsp_data[0]); end
        @(negedge clk);
        flush[0] = 1'b1; rsp_ready[0] = 1'b1; req_valid[0] = 1'b1;
        #1;
        n_checks++;
        if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL flush_masks_ready: got %b want 0", req_ready[0]); end
        @(posedge clk);
        #1 flush[0] = 1'b0; rsp_ready[0] = 1'b0; req_valid[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || mult_en[0] !== 1'b0) begin
            n_fail++; $display("FAIL flush_done: got v=%b rdy=%b men=%b want 0 1 0", rsp_valid[0], req_ready[0], mult_en[0]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, got, held; int blat; logic [3:0] enf; logic ena; logic rdy;
        do_op(0, 2'd0, 2'b00, 32'd6, 32'd7, ok, blat, held, enf, ena);
        n_checks++;
        if (!ok || rsp_data[0] !== 32'd42) begin n_fail++; $display("FAIL b2b_first: got ok=%b %0d want 1 42", ok, rsp_data[0]); end
        rsp_ready[0] = 1'b1;
        req_op = 2'd2; req_signed = 2'b00; req_a = 32'd100; req_b = 32'd7; req_valid[0] = 1'b1;
        #1 rdy = req_ready[0];
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0; req_valid[0] = 1'b0;
        wait_rsp(0, 32'd100, 32'd7, got, blat, held, enf, ena);
        n_checks++;
        if (rdy !== 1'b1 || enf !== 4'b0011) begin
            n_fail++; $display("FAIL b2b_accept: got rdy=%b en=%b want 1 0011", rdy, enf);
        end
        n_checks++;
        if (!got || rsp_data[0] !== 32'd14) begin n_fail++; $display("FAIL b2b_div: got ok=%b %0d want 1 14", got, rsp_data[0]); end
        take(0);
    endtask

    task automatic test_reset_mid();
        bit acc, ok, held; int blat; logic [3:0] enf; logic ena;
        send(0, 2'd2, 2'b11, 32'd1000, 32'd3, acc);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mult_en[0], div_en[0], mult_sel[0], div_sel[0], rsp_valid[0], req_ready[0]} !== 6'b000001) begin
            n_fail++; $display("FAIL rstmid_ctrl: got %b want 000001", {mult_en[0], div_en[0], mult_sel[0], div_sel[0], rsp_valid[0], req_ready[0]});
        end
        n_checks++;
        if ({md_operator[0], md_signed[0], op_a[0], op_b[0], rsp_data[0], rsp_lat0} !== 106'd0) begin
            n_fail++; $display("FAIL rstmid_regs: got op=%h a=%h b=%h data=%h lat=%0d want 0", md_operator[0], op_a[0], op_b[0], rsp_data[0], rsp_lat0);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 2'd0, 2'b00, 32'd3, 32'd4, ok, blat, held, enf, ena);
        n_checks++;
        if (!ok || rsp_data[0] !== 32'd12) begin n_fail++; $display("FAIL rstmid_next: got ok=%b %0d want 1 12", ok, rsp_data[0]); end
        take(0);
    endtask

    initial begin
        rst = 1'b1;
        req_op = 2'd0; req_signed = 2'd0; req_a = 32'd0; req_b = 32'd0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; flush[d] = 1'b0; rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_mull_hold();
        test_mulh_div();
        test_div_zero();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
